extmem_ctrl: RTL and testbench
==============================

EXTMEM_CTRL -- requirements
Module: extmem_ctrl

Interface
REQ-001 Parameter LINE_WORDS, default 4, SHALL set words per read line fill (power of 2, 2..8).
REQ-002 Parameter MAX_WAIT, default 15, SHALL set cycles allowed per memory beat without mem_done before error.
REQ-003 ph1  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 resetb  in  1  reset, synchronous, active-low.
REQ-005 req  in  1  CPU-side request valid.
REQ-006 req_rwb  in  1  1 = line read, 0 = single-word write.
REQ-007 req_adr  in  13  word address.
REQ-008 req_wdata  in  32  write data; req_byteen  in  4  write byte enables (bit0 = data[7:0]).
REQ-009 ack  out  1  request accepted this cycle (req & ack = transfer).
REQ-010 rvalid  out  1  rdata valid; rdata  out  32; rword  out  log2(LINE_WORDS)  word index; rlast  out  1  final beat of line.
REQ-011 busy  out  1; err  out  1  sticky timeout flag.
REQ-012 mem_adr  out  13; mem_data  inout  32; mem_byteen  out  4; mem_rwb  out  1; mem_en  out  1; mem_done  in  1.

Function
REQ-013 States SHALL be IDLE, RD, WR, ERR.
REQ-014 ack SHALL be combinational: req & (state==IDLE) & ~err, subject to REQ-029.
REQ-015 Read accept SHALL enter RD with beat index = req_adr[log2(LINE_WORDS)-1:0] (critical word first), line base = upper bits.
REQ-016 In RD: mem_en=1, mem_rwb=1, mem_byteen=0000, mem_adr={base,index}; mem_data SHALL be high-Z.
REQ-017 Each ph1 edge with mem_done=1 in RD SHALL register mem_data into rdata, set rvalid=1 next cycle, rword=index, increment index modulo LINE_WORDS (wrap within line).
REQ-018 After LINE_WORDS beats rlast SHALL accompany the last rvalid and state SHALL return to IDLE at the same edge; with mem_done tied high, beat k appears on rvalid in cycle k+2 after the accept edge.
REQ-019 Write accept SHALL enter WR: mem_en=1, mem_rwb=0, mem_adr=req_adr, mem_byteen=req_byteen, mem_data driven with req_wdata (registered); on mem_done at an edge, return to IDLE.
REQ-020 mem_rwb SHALL be 0 only in WR (downstream memory writes on any ph1 edge with rwb=0, regardless of en).
REQ-021 rvalid SHALL be a one-cycle pulse per beat; rdata SHALL hold its value between beats.
REQ-022 A wait counter SHALL clear on every accepted beat and on state entry; reaching MAX_WAIT in RD/WR SHALL enter ERR.
REQ-023 ERR: mem_en=0, mem_rwb=1, bus high-Z, err=1, ack=0, until reset.
REQ-024 busy SHALL equal (state!=IDLE) | write buffer occupied.

Reset
REQ-025 resetb low at a ph1 edge SHALL force, at any point mid-transfer: state IDLE, mem_en 0, mem_rwb 1, mem_byteen 0, mem_adr 0, bus high-Z, rvalid 0, rlast 0, rdata 0, rword 0, err 0, counters 0, write buffer empty.
REQ-026 A line fill interrupted by reset SHALL produce no further rvalid.

Configuration
REQ-027 Macro EXTMEM_CTRL_WBUF_EN SHALL compile in a one-entry posted write buffer.
REQ-028 With it: writes SHALL be acked whenever the buffer is empty (including during RD), completing on the CPU side immediately; buffer drains via WR at the next IDLE.
REQ-029 With it: in IDLE with buffer full, drain SHALL take priority; read requests SHALL not be acked until the buffer is empty (read-after-write ordering).
REQ-030 Without it: writes SHALL be acked only in IDLE and state WR SHALL hold the transfer as in REQ-019.

Structure
REQ-031 Package extmem_pkg SHALL hold the state encoding type, ADR_W=13, DATA_W=32, BE_W=4 constants.
REQ-032 Write buffer SHALL be sub-module extmem_wbuf (address, data, byteen, valid), instantiated only under EXTMEM_CTRL_WBUF_EN.

Verification
REQ-033 Read req_adr=0x006, LINE_WORDS=4, mem_done=1 -> mem_adr 0x006,0x007,0x004,0x005; rword 2,3,0,1; rlast with rword 1; first rvalid 2 cycles after accept.
REQ-034 Write adr=0x010, data=0xDEADBEEF, byteen=0101 -> one WR cycle, mem_rwb=0 only that cycle, memory word bytes 0 and 2 updated.
REQ-035 mem_done held 0 for 16 cycles in RD (MAX_WAIT=15) -> err=1, mem_en=0, subsequent req not acked until resetb pulse.
REQ-036 resetb low at beat 2 of a fill -> next cycle all outputs at reset values, no further rvalid, ack returns in IDLE.
REQ-037 EXTMEM_CTRL_WBUF_EN: write then read same cycle-back-to-back to 0x020 -> write acked at once, read ack delayed until drain, read returns written data.
REQ-038 mem_done stalls of 3 cycles per beat -> rvalid spacing 4 cycles, no timeout, data order preserved.

Source files
------------

// File: rtl/extmem_pkg.sv
// extmem_pkg: shared widths and controller state encoding
package extmem_pkg;
  localparam int ADR_W  = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;
endpackage

// File: rtl/extmem_ctrl_if.sv
// extmem_ctrl_if: CPU-side request/response bus of extmem_ctrl
interface extmem_ctrl_if #(parameter int LINE_WORDS = 4) ();
  import extmem_pkg::*;
  localparam int IW = $clog2(LINE_WORDS);
  logic              req;
  logic              req_rwb;
  logic [ADR_W-1:0]  req_adr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_byteen;
  logic              ack;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [IW-1:0]     rword;
  logic              rlast;
  logic              busy;
  logic              err;
  modport master (output req, req_rwb, req_adr, req_wdata, req_byteen,
                  input ack, rvalid, rdata, rword, rlast, busy, err);
  modport slave (input req, req_rwb, req_adr, req_wdata, req_byteen,
                 output ack, rvalid, rdata, rword, rlast, busy, err);
endinterface

// File: rtl/extmem_wbuf.sv
// extmem_wbuf: one-entry posted write buffer
module extmem_wbuf import extmem_pkg::*; (
  input  logic              ph1,
  input  logic              resetb,
  input  logic              load,
  input  logic              drain,
  input  logic [ADR_W-1:0]  req_adr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_byteen,
  output logic [ADR_W-1:0]  adr,
  output logic [DATA_W-1:0] data,
  output logic [BE_W-1:0]   byteen,
  output logic              valid
);
  always_ff @(posedge ph1)
    if (!resetb) begin
      adr <= '0;
      data <= '0;
      byteen <= '0;
      valid <= 1'b0;
    end else if (load) begin
      adr <= req_adr;
      data <= req_wdata;
      byteen <= req_byteen;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/extmem_ctrl.sv
// extmem_ctrl: critical-word-first line fill and word write controller; EXTMEM_CTRL_WBUF_EN adds a posted write buffer
module extmem_ctrl import extmem_pkg::*; #(
  parameter int LINE_WORDS = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic              ph1,
  input  logic              resetb,
  extmem_ctrl_if.slave      cpu,
  output logic [ADR_W-1:0]  mem_adr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic [BE_W-1:0]   mem_byteen,
  output logic              mem_rwb,
  output logic              mem_en,
  input  logic              mem_done
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_t state, nxt;
  logic [ADR_W-IW-1:0] base;
  logic [IW-1:0] idx, cnt, rword;
  logic [WW-1:0] wcnt;
  logic [DATA_W-1:0] rdata, w_data;
  logic [ADR_W-1:0] w_adr;
  logic [BE_W-1:0] w_be;
  logic rvalid, rlast, w_valid, rd_ack, wr_ack, go_wr, active, beat, wdone, last, timeout;
`ifdef EXTMEM_CTRL_WBUF_EN
  assign wr_ack = cpu.req & ~cpu.req_rwb & ~w_valid & (state != ERR);
  assign go_wr = w_valid;
  extmem_wbuf u_wbuf (
    .ph1(ph1), .resetb(resetb), .load(wr_ack), .drain(wdone),
    .req_adr(cpu.req_adr), .req_wdata(cpu.req_wdata), .req_byteen(cpu.req_byteen),
    .adr(w_adr), .data(w_data), .byteen(w_be), .valid(w_valid)
  );
`else
  assign wr_ack = cpu.req & ~cpu.req_rwb & (state == IDLE);
  assign go_wr = wr_ack;
  assign w_valid = 1'b0;
  always_ff @(posedge ph1)
    if (!resetb) begin
      w_adr <= '0;
      w_data <= '0;
      w_be <= '0;
    end else if (wr_ack) begin
      w_adr <= cpu.req_adr;
      w_data <= cpu.req_wdata;
      w_be <= cpu.req_byteen;
    end
`endif
  always_comb begin
    rd_ack = cpu.req & cpu.req_rwb & (state == IDLE) & ~w_valid;
    active = (state == RD) | (state == WR);
    beat = (state == RD) & mem_done;
    wdone = (state == WR) & mem_done;
    last = cnt == IW'(LINE_WORDS - 1);
    timeout = active & ~mem_done & (wcnt == WW'(MAX_WAIT));
    nxt = state;
    case (state)
      IDLE: nxt = rd_ack ? RD : go_wr ? WR : IDLE;
      RD:   nxt = timeout ? ERR : (beat & last) ? IDLE : RD;
      WR:   nxt = timeout ? ERR : wdone ? IDLE : WR;
      default: nxt = ERR;
    endcase
  end
  always_ff @(posedge ph1)
    if (!resetb) begin
      state <= IDLE;
      base <= '0;
      idx <= '0;
      cnt <= '0;
      wcnt <= '0;
      rvalid <= 1'b0;
      rlast <= 1'b0;
      rdata <= '0;
      rword <= '0;
    end else begin
      state <= nxt;
      wcnt <= (active & ~mem_done & (nxt == state)) ? wcnt + 1'b1 : '0;
      rvalid <= beat;
      rlast <= beat & last;
      if (rd_ack) begin
        base <= cpu.req_adr[ADR_W-1:IW];
        idx <= cpu.req_adr[IW-1:0];
        cnt <= '0;
      end else if (beat) begin
        idx <= idx + 1'b1;
        cnt <= cnt + 1'b1;
      end
      if (beat) begin
        rdata <= mem_data;
        rword <= idx;
      end
    end
  assign cpu.ack = rd_ack | wr_ack;
  assign cpu.rvalid = rvalid;
  assign cpu.rdata = rdata;
  assign cpu.rword = rword;
  assign cpu.rlast = rlast;
  assign cpu.busy = (state != IDLE) | w_valid;
  assign cpu.err = state == ERR;
  assign mem_en = active;
  assign mem_rwb = state != WR;
  assign mem_adr = (state == RD) ? {base, idx} : (state == WR) ? w_adr : '0;
  assign mem_byteen = (state == WR) ? w_be : '0;
  assign mem_data = (state == WR) ? w_data : 'z;
endmodule

// File: tb/tb_extmem_ctrl.sv
// tb_extmem_ctrl: randomized self-checking bench for extmem_ctrl against a word-array memory model
module tb_extmem_ctrl;
  import extmem_pkg::*;
  logic ph1 = 1'b0, resetb = 1'b0, hold_off = 1'b0;
  logic [ADR_W-1:0] mem_adr;
  wire [DATA_W-1:0] mem_data;
  logic [BE_W-1:0] mem_byteen;
  logic mem_rwb, mem_en, mem_done;
  logic [31:0] mem [0:8191];
  logic [31:0] ref_mem [0:8191];
  int stall = 0, sc = 0, n_cmp = 0, n_bad = 0;

  extmem_ctrl_if #(.LINE_WORDS(4)) cpu ();
  extmem_ctrl #(.LINE_WORDS(4), .MAX_WAIT(15)) dut (
    .ph1(ph1), .resetb(resetb), .cpu(cpu.slave),
    .mem_adr(mem_adr), .mem_data(mem_data), .mem_byteen(mem_byteen),
    .mem_rwb(mem_rwb), .mem_en(mem_en), .mem_done(mem_done)
  );

  always #5 ph1 = ~ph1;
  assign mem_done = mem_en && !hold_off && sc >= stall;
  assign mem_data = (mem_en && mem_rwb) ? mem[mem_adr] : 'z;
  always @(posedge ph1) begin
    sc <= (!mem_en || mem_done) ? 0 : sc + 1;
    if (!mem_rwb)
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) mem[mem_adr][8*b +: 8] <= mem_data[8*b +: 8];
  end

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic do_reset();
    cpu.req = 1'b0;
    resetb = 1'b0;
    repeat (2) @(negedge ph1);
    resetb = 1'b1;
  endtask

  task automatic read_line(input logic [12:0] adr, input int s, output int waited);
    logic [12:0] exp_a [4];
    logic [31:0] exp_d [4];
    logic [31:0] last_d;
    int k, j;
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = {adr[12:2], 2'(adr[1:0] + i)};
      exp_d[i] = ref_mem[exp_a[i]];
    end
    stall = s;
    waited = 0;
    cpu.req = 1'b1; cpu.req_rwb = 1'b1; cpu.req_adr = adr;
    #1;
    while (!cpu.ack && waited < 50) begin @(negedge ph1); #1; waited++; end
    n_cmp++;
    if (!cpu.ack) begin
      n_bad++; cpu.req = 1'b0;
      $display("FAIL rd_ack adr=%h got ack=%b want 1 within 50 cycles", adr, cpu.ack);
      return;
    end
    @(negedge ph1);
    cpu.req = 1'b0;
    k = 0; j = 0; last_d = 0;
    for (int t = 1; t <= 60 && k < 4; t++) begin
      if (t > 1) @(negedge ph1);
      if (mem_en && mem_rwb && mem_done && j < 4) begin
        n_cmp++;
        if (mem_adr !== exp_a[j]) begin
          n_bad++; $display("FAIL rd_madr beat=%0d got %h want %h", j, mem_adr, exp_a[j]);
        end
        j++;
      end
      if (cpu.rvalid) begin
        n_cmp++;
        if (t != (k + 1) * (s + 1) + 1 || cpu.rdata !== exp_d[k] || cpu.rword !== exp_a[k][1:0] || cpu.rlast !== (k == 3)) begin
          n_bad++;
          $display("FAIL rd_beat adr=%h k=%0d got t=%0d data=%h word=%0d last=%b want t=%0d data=%h word=%0d last=%b",
                   adr, k, t, cpu.rdata, cpu.rword, cpu.rlast, (k + 1) * (s + 1) + 1, exp_d[k], exp_a[k][1:0], k == 3);
        end
        last_d = cpu.rdata;
        k++;
      end else if (k > 0) begin
        n_cmp++;
        if (cpu.rdata !== last_d) begin
          n_bad++; $display("FAIL rd_hold got %h want %h", cpu.rdata, last_d);
        end
      end
    end
    n_cmp++;
    if (k != 4 || cpu.busy) begin
      n_bad++; $display("FAIL rd_done adr=%h got beats=%0d busy=%b want 4 busy=0", adr, k, cpu.busy);
    end
  endtask

  task automatic write_word(input logic [12:0] adr, input logic [31:0] d, input logic [3:0] be, input int s);
    int waited = 0, wr = 0;
    stall = s;
    cpu.req = 1'b1; cpu.req_rwb = 1'b0; cpu.req_adr = adr; cpu.req_wdata = d; cpu.req_byteen = be;
    #1;
    while (!cpu.ack && waited < 50) begin @(negedge ph1); #1; waited++; end
    n_cmp++;
    if (!cpu.ack) begin
      n_bad++; cpu.req = 1'b0;
      $display("FAIL wr_ack adr=%h got ack=%b want 1 within 50 cycles", adr, cpu.ack);
      return;
    end
    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[adr][8*b +: 8] = d[8*b +: 8];
    @(negedge ph1);
    cpu.req = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (!mem_rwb) begin
        wr++; n_cmp++;
        if ({mem_adr, mem_byteen, mem_data} !== {adr, be, d}) begin
          n_bad++;
          $display("FAIL wr_bus got adr=%h be=%b data=%h want adr=%h be=%b data=%h", mem_adr, mem_byteen, mem_data, adr, be, d);
        end
      end
      if (!cpu.busy) break;
      @(negedge ph1);
    end
    n_cmp++;
    if (wr != s + 1 || cpu.busy || mem[adr] !== ref_mem[adr]) begin
      n_bad++;
      $display("FAIL wr_done adr=%h got wr_cycles=%0d busy=%b word=%h want %0d 0 %h", adr, wr, cpu.busy, mem[adr], s + 1, ref_mem[adr]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    resetb = 1'b0;
    @(negedge ph1);
    n_cmp++;
    if ({cpu.rvalid, cpu.rlast, cpu.rdata, cpu.rword, cpu.err, cpu.busy, cpu.ack, mem_en, mem_rwb, mem_adr, mem_byteen}
        !== {1'b0, 1'b0, 32'h0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset_vals got rv=%b rl=%b rd=%h rw=%0d err=%b busy=%b ack=%b en=%b rwb=%b adr=%h be=%b want all 0 except rwb=1",
               cpu.rvalid, cpu.rlast, cpu.rdata, cpu.rword, cpu.err, cpu.busy, cpu.ack, mem_en, mem_rwb, mem_adr, mem_byteen);
    end
    resetb = 1'b1;
    @(negedge ph1);
  endtask

  task automatic test_read_basic();
    int w;
    read_line(13'h006, 0, w);
    n_cmp++;
    if (w != 0) begin n_bad++; $display("FAIL rd_idle_ack got wait=%0d want 0", w); end
  endtask

  task automatic test_write();
    int w;
    write_word(13'h010, 32'hDEADBEEF, 4'b0101, 0);
    n_cmp++;
    if (mem[16] !== {seed_word(16)[31:24], 8'hAD, seed_word(16)[15:8], 8'hEF}) begin
      n_bad++; $display("FAIL wr_bytes got %h want bytes 2,0 = AD,EF over %h", mem[16], seed_word(16));
    end
    read_line(13'h010, 0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    read_line(13'h101, 0, w);
    read_line(13'h203, 0, w);
    n_cmp++;
    if (w != 0) begin n_bad++; $display("FAIL b2b_ack got wait=%0d want 0", w); end
  endtask

  task automatic test_stall();
    int w;
    read_line(13'h03B, 3, w);
    write_word(13'h03C, $urandom, 4'hF, 2);
    read_line(13'h03C, 1, w);
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 1) == 1)
        read_line(13'($urandom_range(0, 31)), $urandom_range(0, 2), w);
      else
        write_word(13'($urandom_range(0, 31)), $urandom, 4'($urandom), $urandom_range(0, 2));
    end
  endtask

`ifdef EXTMEM_CTRL_WBUF_EN
  task automatic test_wbuf();
    int w;
    logic [31:0] d;
    d = $urandom;
    stall = 0;
    cpu.req = 1'b1; cpu.req_rwb = 1'b0; cpu.req_adr = 13'h020; cpu.req_wdata = d; cpu.req_byteen = 4'hF;
    #1;
    n_cmp++;
    if (cpu.ack !== 1'b1) begin n_bad++; $display("FAIL wbuf_wr_ack got %b want 1", cpu.ack); end
    ref_mem[13'h020] = d;
    @(negedge ph1);
    read_line(13'h020, 0, w);
    n_cmp++;
    if (w == 0) begin n_bad++; $display("FAIL wbuf_raw got read wait=%0d want >0", w); end
  endtask
`endif

  task automatic test_reset_mid();
    int k = 0, seen = 0, w;
    stall = 0;
    cpu.req = 1'b1; cpu.req_rwb = 1'b1; cpu.req_adr = 13'h00A;
    @(negedge ph1);
    cpu.req = 1'b0;
    for (int t = 0; t < 20 && k < 2; t++) begin
      @(negedge ph1);
      if (cpu.rvalid) k++;
    end
    resetb = 1'b0;
    @(negedge ph1);
    n_cmp++;
    if ({cpu.rvalid, cpu.rlast, cpu.rdata, cpu.rword, cpu.err, cpu.busy, mem_en, mem_rwb, mem_adr, mem_byteen}
        !== {1'b0, 1'b0, 32'h0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0, 4'h0}) begin
      n_bad++;
      $display("FAIL midreset_vals got rv=%b rl=%b rd=%h rw=%0d err=%b busy=%b en=%b rwb=%b adr=%h be=%b want all 0 except rwb=1",
               cpu.rvalid, cpu.rlast, cpu.rdata, cpu.rword, cpu.err, cpu.busy, mem_en, mem_rwb, mem_adr, mem_byteen);
    end
    resetb = 1'b1;
    repeat (8) begin @(negedge ph1); if (cpu.rvalid) seen++; end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL midreset_rvalid got %0d pulses want 0", seen); end
    read_line(13'h00A, 0, w);
    n_cmp++;
    if (w != 0) begin n_bad++; $display("FAIL midreset_ack got wait=%0d want 0", w); end
  endtask

  task automatic test_timeout();
    int acks = 0, w;
    hold_off = 1'b1;
    cpu.req = 1'b1; cpu.req_rwb = 1'b1; cpu.req_adr = 13'h044;
    #1;
    n_cmp++;
    if (cpu.ack !== 1'b1) begin n_bad++; $display("FAIL to_ack got %b want 1", cpu.ack); end
    @(negedge ph1);
    cpu.req = 1'b0;
    for (int t = 1; t <= 17; t++) begin
      if (t > 1) @(negedge ph1);
      if (t == 16) begin
        n_cmp++;
        if (cpu.err !== 1'b0 || cpu.busy !== 1'b1) begin
          n_bad++; $display("FAIL to_early got err=%b busy=%b want 0 1", cpu.err, cpu.busy);
        end
      end
      if (t == 17) begin
        n_cmp++;
        if ({cpu.err, mem_en, mem_rwb} !== 3'b101) begin
          n_bad++; $display("FAIL to_err got err=%b en=%b rwb=%b want 1 0 1", cpu.err, mem_en, mem_rwb);
        end
      end
    end
    hold_off = 1'b0;
    cpu.req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cpu.req_rwb = i[0];
      #1;
      if (cpu.ack) acks++;
      @(negedge ph1);
    end
    n_cmp++;
    if (acks != 0 || cpu.err !== 1'b1) begin
      n_bad++; $display("FAIL to_sticky got acks=%0d err=%b want 0 1", acks, cpu.err);
    end
    do_reset();
    read_line(13'h044, 0, w);
    n_cmp++;
    if (w != 0) begin n_bad++; $display("FAIL to_recover got wait=%0d want 0", w); end
  endtask

  initial begin
    cpu.req = 1'b0; cpu.req_rwb = 1'b1; cpu.req_adr = '0; cpu.req_wdata = '0; cpu.req_byteen = '0;
    for (int i = 0; i < 8192; i++) begin
      mem[i] <= seed_word(i);
      ref_mem[i] = seed_word(i);
    end
    test_reset();
    test_read_basic();
    test_write();
    test_back_to_back();
    test_stall();
    test_random();
`ifdef EXTMEM_CTRL_WBUF_EN
    test_wbuf();
`endif
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got no finish want finish before 300000");
    $fatal(1);
  end
endmodule
